// File: rtl/wshb_sram_slave.sv
// wshb_sram_slave: Wishbone B3 slave over a single-port RAM with classic cycles and cti/bte bursts.
// Define WSHB_SRAM_ERR_EN to answer out-of-range word addresses with err instead of aliasing.
module wshb_sram_slave #(
  parameter int DATA_W = 32,
  parameter int ADR_W  = 32,
  parameter int DEPTH  = 1024,
  parameter int WAIT   = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cyc,
  input  logic                stb,
  input  logic [ADR_W-1:0]    adr,
  input  logic                we,
  input  logic [DATA_W-1:0]   dat_ms,
  input  logic [DATA_W/8-1:0] sel,
  input  logic [2:0]          cti,
  input  logic [1:0]          bte,
  output logic                ack,
  output logic                err,
  output logic                rty,
  output logic [DATA_W-1:0]   dat_sm
);
  localparam int IW = $clog2(DEPTH);
  localparam int SW = DATA_W / 8;
  localparam logic [3:0] WAIT_LD = 4'((WAIT > 0) ? (WAIT - 1) : 0);

  typedef enum logic [1:0] {IDLE, WAITST, CLASSIC_ACK, BURST} state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t          state_q, state_d;
  logic [3:0]      wcnt_q, wcnt_d;
  logic            burst_q, burst_d;
  logic [IW-1:0]   bcnt_q, bcnt_d;
  logic            ack_p1, ack_d;
  logic            err_p1, err_d;
  logic [DATA_W-1:0] rdat_p1;

  logic            start, is_burst;
  logic            ld_rd, clr_rd, wr_en;
  logic [IW-1:0]   rd_idx, wr_idx;
  logic [IW-1:0]   adr_idx;
  logic            oob;
  logic            unused_adr;

  assign adr_idx = adr[IW+1:2];

`ifdef WSHB_SRAM_ERR_EN
  assign oob        = |(adr >> (IW + 2));
  assign unused_adr = ^adr[1:0];
`else
  assign oob        = 1'b0;
  assign unused_adr = ^{adr[ADR_W-1:IW+2], adr[1:0]};
`endif

  // Wrapping bursts only advance the low bits inside the aligned 4/8/16-word block.
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] cur, input logic [1:0] mode);
    logic [IW-1:0] inc;
    logic [IW-1:0] mask;
    inc = cur + 1'b1;
    case (mode)
      2'b01:   mask = IW'(3);
      2'b10:   mask = IW'(7);
      2'b11:   mask = IW'(15);
      default: mask = '1;
    endcase
    return (cur & ~mask) | (inc & mask);
  endfunction

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    burst_d  = burst_q;
    bcnt_d   = bcnt_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    start    = 1'b0;
    is_burst = 1'b0;
    ld_rd    = 1'b0;
    clr_rd   = 1'b0;
    rd_idx   = bcnt_q;
    wr_en    = 1'b0;
    wr_idx   = bcnt_q;
    case (state_q)
      IDLE: begin
        if (cyc && stb) begin
          bcnt_d  = adr_idx;
          burst_d = (cti == 3'b010);
          if (WAIT > 0) begin
            state_d = WAITST;
            wcnt_d  = WAIT_LD;
          end else begin
            start = 1'b1;
          end
        end
      end
      WAITST: begin
        if (!cyc)
          state_d = IDLE;
        else if (wcnt_q == 4'd0)
          start = 1'b1;
        else
          wcnt_d = wcnt_q - 4'd1;
      end
      CLASSIC_ACK: state_d = IDLE;
      BURST: begin
        if (!cyc) begin
          state_d = IDLE;
        end else if (stb && ack_p1) begin
          wr_en  = we;
          wr_idx = bcnt_q;
          bcnt_d = next_idx(bcnt_q, bte);
          ld_rd  = 1'b1;
          rd_idx = bcnt_d;
          if (cti == 3'b111)
            state_d = IDLE;
          else
            ack_d = 1'b1;
        end else begin
          // Registered ack follows stb one cycle later; counter and data hold meanwhile.
          ack_d = stb;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      is_burst = (state_q == IDLE) ? (cti == 3'b010) : burst_q;
      if (oob) begin
        state_d = CLASSIC_ACK;
        err_d   = 1'b1;
        clr_rd  = 1'b1;
      end else if (is_burst) begin
        state_d = BURST;
        ack_d   = 1'b1;
        ld_rd   = 1'b1;
        rd_idx  = (state_q == IDLE) ? adr_idx : bcnt_q;
      end else begin
        state_d = CLASSIC_ACK;
        ack_d   = 1'b1;
        ld_rd   = 1'b1;
        rd_idx  = adr_idx;
        wr_en   = we;
        wr_idx  = adr_idx;
      end
    end
  end

  // Stage p1: registered bus responses and read data
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wcnt_q  <= 4'd0;
      burst_q <= 1'b0;
      bcnt_q  <= '0;
      ack_p1  <= 1'b0;
      err_p1  <= 1'b0;
      rdat_p1 <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      burst_q <= burst_d;
      bcnt_q  <= bcnt_d;
      ack_p1  <= ack_d;
      err_p1  <= err_d;
      if (clr_rd)
        rdat_p1 <= '0;
      else if (ld_rd)
        rdat_p1 <= mem[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      for (int b = 0; b < SW; b++)
        if (sel[b]) mem[wr_idx][8*b +: 8] <= dat_ms[8*b +: 8];
    end
  end

  assign ack    = ack_p1;
  assign err    = err_p1;
  assign rty    = 1'b0;
  assign dat_sm = rdat_p1;

endmodule

// File: tb/tb_wshb_sram_slave.sv
// tb_wshb_sram_slave: vector table, directed burst corner sequences and random traffic
// checked against a word-array model of the RAM; a second instance runs with WAIT=3.
`timescale 1ns/1ps
module tb_wshb_sram_slave;
  localparam int DEPTH = 1024;
  localparam int WAIT2 = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mcyc = 1'b0, mstb = 1'b0, sel_dut = 1'b0;
  logic        cyc, stb, cyc2, stb2;
  logic [31:0] adr = '0, dat_ms = '0;
  logic        we = 1'b0;
  logic [3:0]  sel = '0;
  logic [2:0]  cti = '0;
  logic [1:0]  bte = '0;
  logic        ack, err, rty, ack2, err2, rty2;
  logic [31:0] dat_sm, dat2;
  logic        m_ack, m_err;
  logic [31:0] m_dat;

  int          total = 0;
  int          bad = 0;
  logic [31:0] refm [2][DEPTH];
  logic [31:0] got [64];

  assign cyc   = mcyc & ~sel_dut;
  assign stb   = mstb & ~sel_dut;
  assign cyc2  = mcyc & sel_dut;
  assign stb2  = mstb & sel_dut;
  assign m_ack = sel_dut ? ack2 : ack;
  assign m_err = sel_dut ? err2 : err;
  assign m_dat = sel_dut ? dat2 : dat_sm;

  always #5 clk = ~clk;

  wshb_sram_slave #(.DATA_W(32), .ADR_W(32), .DEPTH(DEPTH), .WAIT(0)) dut (
    .clk(clk), .rst(rst), .cyc(cyc), .stb(stb), .adr(adr), .we(we), .dat_ms(dat_ms),
    .sel(sel), .cti(cti), .bte(bte), .ack(ack), .err(err), .rty(rty), .dat_sm(dat_sm));

  wshb_sram_slave #(.DATA_W(32), .ADR_W(32), .DEPTH(DEPTH), .WAIT(WAIT2)) dut_w (
    .clk(clk), .rst(rst), .cyc(cyc2), .stb(stb2), .adr(adr), .we(we), .dat_ms(dat_ms),
    .sel(sel), .cti(cti), .bte(bte), .ack(ack2), .err(err2), .rty(rty2), .dat_sm(dat2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  function automatic int wt();
    return sel_dut ? WAIT2 : 0;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Word touched by beat k: linear runs modulo DEPTH, wraps stay in the aligned block.
  function automatic int baddr(input int w0, input int k, input logic [1:0] bt);
    int len;
    case (bt)
      2'b01:   len = 4;
      2'b10:   len = 8;
      2'b11:   len = 16;
      default: len = DEPTH;
    endcase
    return (w0 / len) * len + (w0 + k) % len;
  endfunction

  task automatic classic(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rd, output logic ak,
                         output logic er, output int lt);
    int n;
    n = 0;
    adr = a; we = w; dat_ms = d; sel = s; cti = 3'b000; bte = 2'b00;
    mcyc = 1'b1; mstb = 1'b1;
    while (!(m_ack || m_err) && n < 40) begin
      tick();
      n++;
    end
    lt = n; rd = m_dat; ak = m_ack; er = m_err;
    mcyc = 1'b0; mstb = 1'b0; we = 1'b0;
    tick();
    chk("classic_resp_once", {30'd0, m_ack, m_err}, 32'd0);
  endtask

  task automatic cwrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd;
    logic ak, er;
    int lt;
    classic(1'b1, a, d, s, rd, ak, er, lt);
    chk("cwrite_lat", 32'(lt), 32'(wt() + 1));
    chk("cwrite_ack", {31'd0, ak}, 32'd1);
    refm[sel_dut][a[11:2]] = merge(refm[sel_dut][a[11:2]], d, s);
  endtask

  task automatic cread(input logic [31:0] a, input string nm);
    logic [31:0] rd;
    logic ak, er;
    int lt;
    classic(1'b0, a, 32'd0, 4'h0, rd, ak, er, lt);
    chk({nm, "_lat"}, 32'(lt), 32'(wt() + 1));
    chk({nm, "_ack"}, {31'd0, ak}, 32'd1);
    chk(nm, rd, refm[sel_dut][a[11:2]]);
  endtask

  task automatic burst(input int w0, input int n, input logic [1:0] bt, input logic w,
                       input logic rsel, input int gap_at, input int gap_len,
                       input int drop_at, input string nm);
    logic [31:0] bdat [65];
    logic [3:0]  bsel [65];
    int beats, it, first, holes, gap_left, n_eff, exp_holes, wa;
    logic acc;
    for (int k = 0; k < 65; k++) begin
      bdat[k] = $urandom;
      bsel[k] = rsel ? 4'($urandom_range(1, 15)) : 4'hF;
    end
    n_eff     = (drop_at >= 0) ? drop_at : n;
    exp_holes = (gap_at > 0 && gap_at < n_eff) ? gap_len : 0;
    adr = 32'(w0) << 2; we = w; bte = bt; cti = 3'b010;
    dat_ms = bdat[0]; sel = bsel[0];
    mcyc = 1'b1; mstb = 1'b1;
    beats = 0; it = 0; first = -1; holes = 0; gap_left = 0;
    while (beats < n && it < 300) begin
      acc = mstb && m_ack;
      if (m_ack && first < 0) first = it;
      else if (!m_ack && first >= 0) holes++;
      if (acc) begin
        got[beats] = m_dat;
        beats++;
      end
      tick();
      it++;
      if (beats == drop_at) break;
      if (gap_left > 0) begin
        gap_left--;
        if (gap_left == 0) mstb = 1'b1;
      end else if (acc && beats == gap_at) begin
        mstb = 1'b0;
        gap_left = gap_len;
      end
      dat_ms = bdat[beats]; sel = bsel[beats];
      cti = (beats == n - 1) ? 3'b111 : 3'b010;
    end
    if (drop_at >= 0) begin
      mcyc = 1'b0; mstb = 1'b0; we = 1'b0;
      tick();
      chk({nm, "_drop_ack"}, {31'd0, m_ack}, 32'd0);
    end else begin
      chk({nm, "_end_ack"}, {31'd0, m_ack}, 32'd0);
      mcyc = 1'b0; mstb = 1'b0; we = 1'b0;
      tick();
    end
    chk({nm, "_first_lat"}, 32'(first), 32'(wt() + 1));
    chk({nm, "_beats"}, 32'(beats), 32'(n_eff));
    chk({nm, "_ack_holes"}, 32'(holes), 32'(exp_holes));
    for (int k = 0; k < beats; k++) begin
      wa = baddr(w0, k, bt);
      if (w) refm[sel_dut][wa] = merge(refm[sel_dut][wa], bdat[k], bsel[k]);
      else   chk({nm, "_data"}, got[k], refm[sel_dut][wa]);
    end
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] exp;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want test end");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [9];
    int   ord4 [4];
    int   ord8 [8];
    logic [31:0] rd;
    logic ak, er;
    int   lt, kind, bt, n, w0, gap_at;
    logic [31:0] d0, d1, d2;

    vt[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0};
    vt[1] = '{1'b0, 32'h10, 32'h0,        4'h0, 32'hDEADBEEF};
    vt[2] = '{1'b1, 32'h10, 32'h000000AA, 4'h1, 32'h0};
    vt[3] = '{1'b0, 32'h10, 32'h0,        4'h0, 32'hDEADBEAA};
    vt[4] = '{1'b1, 32'h14, 32'h12345678, 4'hF, 32'h0};
    vt[5] = '{1'b1, 32'h14, 32'hAABBCCDD, 4'h6, 32'h0};
    vt[6] = '{1'b0, 32'h14, 32'h0,        4'h0, 32'h12BBCC78};
    vt[7] = '{1'b1, 32'h3C, 32'h00000000, 4'hF, 32'h0};
    vt[8] = '{1'b0, 32'h3C, 32'h0,        4'h0, 32'h00000000};
    ord4 = '{6, 7, 4, 5};
    ord8 = '{5, 6, 7, 0, 1, 2, 3, 4};

    repeat (3) tick();
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_rty", {31'd0, rty}, 32'd0);
    chk("rst_dat", dat_sm, 32'd0);
    chk("rst_ack_w", {31'd0, ack2}, 32'd0);
    chk("rst_dat_w", dat2, 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_ack", {31'd0, ack}, 32'd0);

    for (int i = 0; i < 9; i++) begin
      classic(vt[i].w, vt[i].a, vt[i].d, vt[i].s, rd, ak, er, lt);
      chk("vec_lat", 32'(lt), 32'd1);
      chk("vec_err", {31'd0, er}, 32'd0);
      if (vt[i].w) refm[0][vt[i].a[11:2]] = merge(refm[0][vt[i].a[11:2]], vt[i].d, vt[i].s);
      else         chk("vec_rdata", rd, vt[i].exp);
    end

    burst(0, 64, 2'b00, 1'b1, 1'b0, -1, 0, -1, "preload");
    for (int k = 0; k < 4; k++) cwrite(32'(k) << 2, 32'(k), 4'hF);

    burst(0, 4, 2'b00, 1'b0, 1'b0, -1, 0, -1, "lin4");
    for (int k = 0; k < 4; k++) chk("lin4_value", got[k], 32'(k));

    burst(6, 4, 2'b01, 1'b0, 1'b0, -1, 0, -1, "wrap4");
    for (int k = 0; k < 4; k++) chk("wrap4_order", got[k], refm[0][ord4[k]]);
    burst(5, 8, 2'b10, 1'b0, 1'b0, -1, 0, -1, "wrap8");
    for (int k = 0; k < 8; k++) chk("wrap8_order", got[k], refm[0][ord8[k]]);

    burst(0, 4, 2'b00, 1'b0, 1'b0, 2, 2, -1, "gap");
    chk("gap_beat3_word2", got[2], 32'd2);

    burst(20, 4, 2'b00, 1'b1, 1'b1, -1, 0, 2, "drop");
    for (int k = 20; k < 24; k++) cread(32'(k) << 2, "drop_readback");

    // Reset lands on a write beat: that beat must not reach the RAM.
    d0 = $urandom; d1 = $urandom; d2 = $urandom;
    adr = 32'(8) << 2; we = 1'b1; sel = 4'hF; cti = 3'b010; bte = 2'b00; dat_ms = d0;
    mcyc = 1'b1; mstb = 1'b1;
    tick();
    tick(); dat_ms = d1;
    tick(); dat_ms = d2;
    refm[0][8] = d0; refm[0][9] = d1;
    rst = 1'b1;
    tick();
    chk("rstmid_ack", {31'd0, ack}, 32'd0);
    chk("rstmid_err", {31'd0, err}, 32'd0);
    rst = 1'b0; we = 1'b0; adr = 32'(10) << 2;
    tick();
    chk("rstmid_restart_ack", {31'd0, ack}, 32'd1);
    chk("rstmid_word10", dat_sm, refm[0][10]);
    cti = 3'b111;
    tick();
    chk("rstmid_end_ack", {31'd0, ack}, 32'd0);
    mcyc = 1'b0; mstb = 1'b0;
    tick();
    for (int k = 8; k < 11; k++) cread(32'(k) << 2, "rstmid_readback");

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 3);
      if (kind == 0) begin
        cwrite(32'($urandom_range(0, 63)) << 2, $urandom, 4'($urandom_range(1, 15)));
      end else if (kind == 1) begin
        cread(32'($urandom_range(0, 63)) << 2, "rnd_cread");
      end else begin
        bt = $urandom_range(0, 3);
        n  = $urandom_range(2, 16);
        w0 = (bt == 0) ? $urandom_range(0, 64 - n) : $urandom_range(0, 63);
        gap_at = ($urandom_range(0, 2) == 0) ? $urandom_range(1, n - 1) : -1;
        burst(w0, n, 2'(bt), 1'($urandom_range(0, 1)), 1'b1, gap_at,
              $urandom_range(1, 3), -1, "rnd_burst");
      end
    end
    for (int k = 0; k < 64; k++) cread(32'(k) << 2, "final_readback");

    classic(1'b0, 32'h1000, 32'd0, 4'h0, rd, ak, er, lt);
`ifdef WSHB_SRAM_ERR_EN
    chk("oob_err", {31'd0, er}, 32'd1);
    chk("oob_ack", {31'd0, ak}, 32'd0);
    chk("oob_dat", rd, 32'd0);
`else
    chk("alias_ack", {31'd0, ak}, 32'd1);
    chk("alias_err", {31'd0, er}, 32'd0);
    chk("alias_dat", rd, refm[0][0]);
`endif

    sel_dut = 1'b1;
    cwrite(32'h0, 32'h0BADF00D, 4'hF);
    cwrite(32'hC, 32'h13572468, 4'hF);
    cread(32'hC, "w3_cread");
    burst(4, 4, 2'b00, 1'b1, 1'b0, -1, 0, -1, "w3_bwrite");
    burst(6, 4, 2'b01, 1'b0, 1'b0, -1, 0, -1, "w3_wrap4");
    burst(0, 8, 2'b00, 1'b0, 1'b0, 3, 2, -1, "w3_gap");
    classic(1'b0, 32'h1000, 32'd0, 4'h0, rd, ak, er, lt);
    chk("w3_oob_lat", 32'(lt), 32'(WAIT2 + 1));
`ifdef WSHB_SRAM_ERR_EN
    chk("w3_oob_err", {31'd0, er}, 32'd1);
    chk("w3_oob_ack", {31'd0, ak}, 32'd0);
    chk("w3_oob_dat", rd, 32'd0);
`else
    chk("w3_alias_ack", {31'd0, ak}, 32'd1);
    chk("w3_alias_dat", rd, 32'h0BADF00D);
`endif
    chk("w3_rty", {31'd0, rty2}, 32'd0);
    sel_dut = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
